// File: rtl/scie_arb_pkg.sv
// Shared types and constants for the SCIE arbiter: filter opcodes, the
// in-flight tracking entry and the lock-state encoding.
package scie_arb_pkg;

  localparam logic [6:0] OP_LOAD_COEF = 7'h0B;
  localparam logic [6:0] OP_PUSH      = 7'h2B;
  localparam logic [6:0] OP_READ      = 7'h5B;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;

  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } inflight_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
    return insn[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/scie_rr_arbiter.sv
// Masked round-robin grant. Picks the first requester that is both valid and
// unmasked, searching upward from rr and wrapping. Purely combinational; the
// pointer and the lock mask are owned by the parent.
module scie_rr_arbiter
  import scie_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  rr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [NREQ-1:0] eligible;
  int              idx;

  assign eligible = valid & mask;

  // Scan from farthest to nearest so the candidate closest to rr wins last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NREQ;
      if (eligible[IDW'(idx)]) begin
        grant              = '0;
        grant[IDW'(idx)]   = 1'b1;
        grant_id           = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/scie_arbiter.sv
// Shares one SCIEPipelined unit among NREQ requesters. Round-robin grant with
// optional per-requester lock so multi-op filter sequences stay contiguous.
// Responses return in issue order LATENCY+1 cycles after the op leaves on
// scie_*. Define SCIE_ARB_TIMEOUT_EN to force-release a lock whose owner
// stays idle for LOCK_TIMEOUT cycles (sets sticky timeout_err).
module scie_arbiter
  import scie_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int LATENCY      = 1,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_lock,
  input  logic [NREQ*32-1:0]     req_insn,
  input  logic [NREQ*32-1:0]     req_rs1,
  input  logic [NREQ*32-1:0]     req_rs2,
  output logic [NREQ-1:0]        resp_valid,
  output logic [31:0]            resp_rd,
  output logic                   scie_valid,
  output logic [31:0]            scie_insn,
  output logic [31:0]            scie_rs1,
  output logic [31:0]            scie_rs2,
  input  logic [31:0]            scie_rd,
  output logic [$clog2(NREQ):0]  lock_owner,
  output logic                   timeout_err
);

  localparam int IDW = $clog2(NREQ);

  lock_state_t            state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         rr_q, rr_d;
  logic [NREQ-1:0]        mask, grant;
  logic [IDW-1:0]         acc_id;
  logic                   accept;
  logic [31:0]            sel_insn, sel_rs1, sel_rs2;
  inflight_t [LATENCY:0]  pipe_q;

`ifdef SCIE_ARB_TIMEOUT_EN
  localparam int              TW       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMR_LOAD = TW'(LOCK_TIMEOUT - 1);
  logic [TW-1:0]              tmr_q, tmr_d;
  logic                       err_q, err_d;
`endif

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
    return (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
  endfunction

  // While locked only the owner is eligible.
  always_comb begin
    mask = '1;
    if (state_q == LOCKED) begin
      mask          = '0;
      mask[owner_q] = 1'b1;
    end
  end

  scie_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .valid    (req_valid),
    .mask     (mask),
    .rr       (rr_q),
    .grant    (grant),
    .grant_id (acc_id)
  );

  // ready is suppressed while reset is held so nothing is accepted in reset.
  assign req_ready = grant & {NREQ{reset}};
  assign accept    = |req_ready;

  // Route the granted requester's payload toward the SCIE inputs.
  always_comb begin
    sel_insn = '0;
    sel_rs1  = '0;
    sel_rs2  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_insn = req_insn[32*i +: 32];
        sel_rs1  = req_rs1[32*i +: 32];
        sel_rs2  = req_rs2[32*i +: 32];
      end
    end
  end

  // Lock FSM and round-robin pointer next-state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
`ifdef SCIE_ARB_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    case (state_q)
      UNLOCKED: begin
        if (accept) begin
          rr_d = inc_id(acc_id);
          if (req_lock[acc_id]) begin
            state_d = LOCKED;
            owner_d = acc_id;
`ifdef SCIE_ARB_TIMEOUT_EN
            tmr_d   = TMR_LOAD;
`endif
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          rr_d = inc_id(acc_id);
`ifdef SCIE_ARB_TIMEOUT_EN
          tmr_d = TMR_LOAD;
`endif
          if (!req_lock[acc_id]) state_d = UNLOCKED;
        end
`ifdef SCIE_ARB_TIMEOUT_EN
        else if (!req_valid[owner_q]) begin
          if (tmr_q == '0) begin
            state_d = UNLOCKED;
            rr_d    = inc_id(owner_q);
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
`endif
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef SCIE_ARB_TIMEOUT_EN
  // Idle-owner timer and sticky forced-unlock flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign lock_owner = (state_q == LOCKED) ? {1'b1, owner_q} : '0;

  // Registered issue to the SCIE unit; payload holds between ops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scie_valid <= 1'b0;
      scie_insn  <= '0;
      scie_rs1   <= '0;
      scie_rs2   <= '0;
    end else begin
      scie_valid <= accept;
      if (accept) begin
        scie_insn <= sel_insn;
        scie_rs1  <= sel_rs1;
        scie_rs2  <= sel_rs2;
      end
    end
  end

  // In-flight tracker: stage 0 lines up with scie_valid, stage LATENCY with scie_rd.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= inflight_t'{valid: accept, id: ID_W'(acc_id)};
      for (int s = 1; s <= LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  // Capture scie_rd and strobe the issuer of the op leaving the tracker.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_rd    <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        resp_valid[i] <= pipe_q[LATENCY].valid && (pipe_q[LATENCY].id == ID_W'(i));
      if (pipe_q[LATENCY].valid) resp_rd <= scie_rd;
    end
  end

endmodule
